// File: rtl/cla_wide_seq_if.sv
//------------------------------------------------------------------------------
// Module : cla_wide_seq_if
// Brief  : Request/result bundle for the limb-serial wide adder/subtractor.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cla_wide_seq_if #(
  parameter int W = 64
);
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         ovf;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, S, Cout, ovf
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, S, Cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/cla_wide_seq.sv
//------------------------------------------------------------------------------
// Module : cla / cla_wide_seq
// Brief  : W-bit add/sub computed one 16-bit limb per clock through one CLA.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cla #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int BLKS = N / 4;

  logic [N-1:0] w_p;
  logic [N-1:0] w_g;
  logic [N-1:0] w_c;
  logic         w_cb;
  logic [3:0]   w_bp;
  logic [3:0]   w_bg;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Full lookahead inside each 4-bit block; block carries ripple between blocks.
  always_comb begin
    w_c  = '0;
    w_cb = cin;
    w_bp = '0;
    w_bg = '0;
    for (int k = 0; k < BLKS; k++) begin
      w_bp         = w_p[4*k +: 4];
      w_bg         = w_g[4*k +: 4];
      w_c[4*k]     = w_cb;
      w_c[4*k + 1] = w_bg[0] | (w_bp[0] & w_cb);
      w_c[4*k + 2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & w_cb);
      w_c[4*k + 3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
                   | (w_bp[2] & w_bp[1] & w_bp[0] & w_cb);
      w_cb         = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1])
                   | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0])
                   | (w_bp[3] & w_bp[2] & w_bp[1] & w_bp[0] & w_cb);
    end
  end

  assign sum  = w_p ^ w_c;
  assign cout = w_cb;
endmodule

module cla_wide_seq #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  cla_wide_seq_if.slave  bus
);
  localparam int LIMBS = W / 16;
  localparam int IW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_s;
  logic           r_carry;
  logic           r_cout;
  logic           r_ovf;
  logic [IW-1:0]  r_idx;
  logic           w_accept;
  logic           w_last;
  logic [15:0]    w_a_limb;
  logic [15:0]    w_b_limb;
  logic [15:0]    w_sum;
  logic           w_cout;

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == IW'(LIMBS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_a_limb = '0;
    w_b_limb = '0;
    for (int k = 0; k < LIMBS; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_limb = r_a[16*k +: 16];
        w_b_limb = r_b[16*k +: 16];
      end
    end
  end

  cla #(.N(16)) u_cla (
    .a    (w_a_limb),
    .b    (w_b_limb),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // B is conditioned at capture so the limb loop is a plain add.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.A;
      r_b     <= bus.sub ? ~bus.B : bus.B;
      r_carry <= bus.Cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      for (int k = 0; k < LIMBS; k++) begin
        if (r_idx == IW'(k)) r_s[16*k +: 16] <= w_sum;
      end
      r_carry <= w_cout;
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_sum[15] != r_a[W-1]);
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.S    = r_s;
  assign bus.Cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_cla_wide_seq.sv
//------------------------------------------------------------------------------
// Module : tb_cla_wide_seq
// Brief  : Directed plus random checks of cla_wide_seq against an arithmetic model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cla_wide_seq;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cla_wide_seq_if #(.W(W)) bus ();

  cla_wide_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result as plain (W+1)-bit arithmetic; overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full};
  endfunction

  function automatic logic [W-1:0] rnd64;
    return {$urandom, $urandom};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit inject, input string tag);
    logic [W+1:0] m;
    int           n;
    bit           seen;
    m       = model(a, b, cin, sub);
    bus.start = 1'b1;
    bus.A   = a;
    bus.B   = b;
    bus.Cin = cin;
    bus.sub = sub;
    tick();
    bus.start = 1'b0;
    bus.A   = rnd64();
    bus.B   = rnd64();
    chk({tag, "_busy"}, W'(bus.busy), W'(1));
    n    = 0;
    seen = 0;
    while (!seen && n < 12) begin
      if (inject && n == 1) begin
        bus.start = 1'b1;
        bus.A     = ~a;
        bus.B     = a;
        bus.Cin   = ~cin;
        bus.sub   = ~sub;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      n++;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, W'(n), W'(4));
    chk({tag, "_S"}, bus.S, m[W-1:0]);
    chk({tag, "_Cout"}, W'(bus.Cout), W'(m[W]));
    chk({tag, "_ovf"}, W'(bus.ovf), W'(m[W+1]));
    tick();
    chk({tag, "_done_width"}, W'(bus.done), W'(0));
  endtask

  logic [W-1:0] pa [3];
  logic [W-1:0] pb [3];
  logic         pc [3];

  initial begin
    logic [W+1:0] m;
    int           n;
    bit           seen;

    rst       = 1'b1;
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.A     = rnd64();
    bus.B     = rnd64();
    bus.Cin   = 1'b1;
    tick();
    bus.A = rnd64();
    bus.B = rnd64();
    tick();
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_S", bus.S, '0);
    chk("rst_Cout", W'(bus.Cout), W'(0));
    chk("rst_ovf", W'(bus.ovf), W'(0));
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("rst_idle", W'(bus.busy), W'(0));

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, "limb_carry");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, "ripple");
    run_op(64'd5, 64'd7, 1'b1, 1'b1, 0, "sub_neg");
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 0, "sub_ovf");
    run_op(64'h1357_9BDF_2468_ACE0, 64'h0F0F_F0F0_1234_5678, 1'b0, 1'b0, 1, "busy_ignore");

    // Abort with reset while the third limb is in flight.
    bus.start = 1'b1;
    bus.A     = rnd64();
    bus.B     = rnd64();
    bus.Cin   = 1'b1;
    bus.sub   = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", W'(bus.busy), W'(0));
    chk("abort_S", bus.S, '0);
    chk("abort_Cout", W'(bus.Cout), W'(0));
    chk("abort_ovf", W'(bus.ovf), W'(0));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) seen = 1;
      tick();
    end
    chk("abort_no_done", W'(seen), W'(0));
    run_op(64'h1234, 64'h1111, 1'b0, 1'b0, 0, "after_abort");

    // Back-to-back with start held high.
    for (int i = 0; i < 3; i++) begin
      pa[i] = rnd64();
      pb[i] = rnd64();
      pc[i] = 1'($urandom_range(0, 1));
    end
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.A     = pa[0];
    bus.B     = pb[0];
    bus.Cin   = pc[0];
    tick();
    for (int i = 0; i < 3; i++) begin
      n    = 0;
      seen = 0;
      while (!seen && n < 12) begin
        tick();
        n++;
        if (bus.done) seen = 1;
      end
      m = model(pa[i], pb[i], pc[i], 1'b0);
      chk($sformatf("b2b%0d_interval", i), W'(n), (i == 0) ? W'(4) : W'(5));
      chk($sformatf("b2b%0d_S", i), bus.S, m[W-1:0]);
      chk($sformatf("b2b%0d_Cout", i), W'(bus.Cout), W'(m[W]));
      if (i < 2) begin
        bus.A   = pa[i+1];
        bus.B   = pb[i+1];
        bus.Cin = pc[i+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    tick();
    chk("b2b_end_idle", W'(bus.busy | bus.done), W'(0));

    for (int i = 0; i < 8; i++) begin
      run_op(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
             $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
